// File: rtl/putc_uart_tx_pkg.sv
// Shared types and helpers for the putc UART transmitter.
package putc_uart_tx_pkg;

  localparam int unsigned RAM_BYTE = 8;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; refuses pushes when full and pops when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/putc_uart_tx.sv
// Buffers putc characters and serialises them as contiguous UART 8N1 frames.
module putc_uart_tx
  import putc_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                putc,
  input  logic [RAM_BYTE-1:0] putc_char,
  output logic                full,
  output logic                idle,
  output logic                overflow,
  output logic                tx
);

  localparam int unsigned CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [RAM_BYTE-1:0] shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                overflow_q, overflow_d;
  logic                pop_c;

  logic                fifo_full, fifo_empty;
  logic [RAM_BYTE-1:0] fifo_dout;
  logic [CW-1:0]       fifo_count;

  sync_fifo #(
    .WIDTH (RAM_BYTE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (putc),
    .din   (putc_char),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UART_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop_c      = 1'b0;
    overflow_d = overflow_q | (putc & fifo_full);

    case (state_q)
      UART_IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_dout;
          cnt_d   = CNT_W'(CPB - 1);
          state_d = UART_START;
        end
      end
      UART_START: begin
        if (cnt_q == '0) begin
          cnt_d     = CNT_W'(CPB - 1);
          bit_idx_d = '0;
          state_d   = UART_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      UART_DATA: begin
        if (cnt_q == '0) begin
          cnt_d     = CNT_W'(CPB - 1);
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = UART_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      UART_STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = fifo_dout;
            cnt_d   = CNT_W'(CPB - 1);
            state_d = UART_START;
          end else begin
            state_d = UART_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = UART_IDLE;
    endcase

    // Line level follows the state being entered so tx stays registered.
    case (state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shift_d[0];
      default:    tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign full     = fifo_full;
  assign idle     = (fifo_count == CW'(0)) && (state_q == UART_IDLE);

endmodule

// File: tb/tb_putc_uart_tx.sv
// Self-checking bench for putc_uart_tx: cycle vectors plus frame decoding.
module tb_putc_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       putc = 1'b0;
  logic [7:0] putc_char = 8'h00;
  logic       full, idle, overflow, tx;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic       dec_en = 1'b1;
  logic [7:0] rx_byte;
  int         rx_t0;
  logic [7:0] rx_q[$];
  int         start_q[$];

  typedef struct {
    logic       putc;
    logic [7:0] ch;
    logic       tx;
    logic       full;
    logic       idle;
    logic       ovf;
  } vec_t;
  vec_t vecs[$];

  putc_uart_tx #(
    .CLK_HZ     (16),
    .BAUD       (4),
    .FIFO_DEPTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .putc      (putc),
    .putc_char (putc_char),
    .full      (full),
    .idle      (idle),
    .overflow  (overflow),
    .tx        (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic add(input logic p, input logic [7:0] c, input logic t, input logic f,
                     input logic i, input logic o, input int n);
    vec_t v;
    v.putc = p; v.ch = c; v.tx = t; v.full = f; v.idle = i; v.ovf = o;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic push_one(input logic [7:0] c);
    putc = 1'b1;
    putc_char = c;
    tick();
    putc = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int c = 0; c < budget && rx_q.size() < n; c++) tick();
    chk("rx_count", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget && !idle; c++) tick();
    chk("drain_idle", 32'(idle), 32'd1);
  endtask

  // Frame decoder: samples mid-bit after a falling start edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (dec_en && tx === 1'b0) begin
        rx_t0 = cyc;
        repeat (6) @(posedge clk);
        #2;
        rx_byte[0] = tx;
        for (int i = 1; i < 8; i++) begin
          repeat (4) @(posedge clk);
          #2;
          rx_byte[i] = tx;
        end
        repeat (4) @(posedge clk);
        #2;
        chk("stop_bit", 32'(tx), 32'd1);
        rx_q.push_back(rx_byte);
        start_q.push_back(rx_t0);
      end
    end
  end

  initial begin
    int idx;

    // 1: reset values and a quiet line
    do_reset();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("quiet_tx", 32'(tx), 32'd1);
    end

    // 2: 0x41 frame, cycle by cycle (bits LSB first 1,0,0,0,0,0,1,0)
    add(1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 20);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5);
    rx_q.delete();
    start_q.delete();
    foreach (vecs[i]) begin
      putc = vecs[i].putc;
      putc_char = vecs[i].ch;
      tick();
      putc = 1'b0;
      chk($sformatf("v%0d_tx", i), 32'(tx), 32'(vecs[i].tx));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].full));
      chk($sformatf("v%0d_idle", i), 32'(idle), 32'(vecs[i].idle));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
    end
    wait_rx(1, 20);
    if (rx_q.size() >= 1) chk("t2_byte", 32'(rx_q[0]), 32'h41);

    // 3: two back-to-back frames, no gap
    rx_q.delete();
    start_q.delete();
    push_one(8'h55);
    push_one(8'hAA);
    repeat (79) tick();
    chk("t3_idle_early", 32'(idle), 32'd0);
    tick();
    chk("t3_idle_80", 32'(idle), 32'd1);
    wait_rx(2, 20);
    if (rx_q.size() >= 2) begin
      chk("t3_byte0", 32'(rx_q[0]), 32'h55);
      chk("t3_byte1", 32'(rx_q[1]), 32'hAA);
      chk("t3_gap", 32'(start_q[1] - start_q[0]), 32'd40);
    end

    // 4: 18 unconditional pushes; the 18th overflows
    rx_q.delete();
    for (int k = 1; k <= 18; k++) begin
      putc = 1'b1;
      putc_char = 8'(k - 1);
      tick();
      chk($sformatf("t4_full_e%0d", k), 32'(full), 32'(k >= 17));
      chk($sformatf("t4_ovf_e%0d", k), 32'(overflow), 32'(k >= 18));
    end
    putc = 1'b0;
    wait_rx(17, 17 * 40 + 60);
    wait_idle(60);
    for (int k = 0; k < 17 && k < rx_q.size(); k++)
      chk($sformatf("t4_byte%0d", k), 32'(rx_q[k]), 32'(k));
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);

    // 5: pushes gated by full, as the top level does
    do_reset();
    chk("t5_ovf_cleared", 32'(overflow), 32'd0);
    rx_q.delete();
    idx = 0;
    for (int c = 0; c < 2000 && idx < 20; c++) begin
      putc = !full;
      putc_char = 8'(32'h20 + idx);
      @(posedge clk);
      if (putc) idx++;
      #1;
      putc = 1'b0;
    end
    chk("t5_pushed", 32'(idx), 32'd20);
    wait_rx(20, 20 * 40 + 60);
    for (int k = 0; k < 20 && k < rx_q.size(); k++)
      chk($sformatf("t5_byte%0d", k), 32'(rx_q[k]), 32'(32'h20 + k));
    chk("t5_no_ovf", 32'(overflow), 32'd0);
    wait_idle(60);

    // 6: reset during the third data bit of 0xFF with three chars queued
    dec_en = 1'b0;
    push_one(8'hFF);
    push_one(8'h01);
    push_one(8'h02);
    push_one(8'h03);
    repeat (11) tick();
    chk("t6_bit2_level", 32'(tx), 32'd1);
    chk("t6_busy", 32'(idle), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_tx", 32'(tx), 32'd1);
    chk("t6_rst_idle", 32'(idle), 32'd1);
    chk("t6_rst_full", 32'(full), 32'd0);
    for (int c = 0; c < 60; c++) begin
      tick();
      chk("t6_quiet_tx", 32'(tx), 32'd1);
    end
    chk("t6_still_idle", 32'(idle), 32'd1);
    rx_q.delete();
    dec_en = 1'b1;
    push_one(8'h00);
    wait_rx(1, 80);
    if (rx_q.size() >= 1) chk("t6_byte", 32'(rx_q[0]), 32'h00);
    wait_idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
